scan_sequencer: RTL and testbench

Upstream stage of the 3-to-8 decoder: generates the 3-bit select code `sel` that drives the decoder's `in`. Supports three modes: free-running scan with a programmable dwell per index, single-step, and direct load. Scan direction is selectable, and a wrap pulse marks each full cycle through the 8 indices. The decoder's one-hot output follows `sel` combinationally.

---
 rtl/scan_sequencer_if.sv | 26 ++
 rtl/scan_sequencer.sv | 86 ++++++++
 tb/tb_scan_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Control and select-code bundle between the scan sequencer and its controller.
// The master drives the scan controls; the slave (sequencer) returns sel/wrap/busy.
`timescale 1ns/1ps
interface scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               run;
  logic               step;
  logic               dir;
  logic               load;
  logic [2:0]         load_val;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               wrap;
  logic               busy;

  modport master (
    output run, step, dir, load, load_val, dwell,
    input  sel, wrap, busy
  );

  modport slave (
    input  run, step, dir, load, load_val, dwell,
    output sel, wrap, busy
  );
endinterface

// File: rtl/scan_sequencer.sv
// 3-bit select-code sequencer (scan with dwell / single-step / direct load) for the 3-to-8 decoder.
// All outputs registered, one edge from inputs; no backpressure, every input is acted on the edge it is sampled.
`timescale 1ns/1ps
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  scan_sequencer_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [2:0]         sel_r;
  logic               wrap_r;
  logic               busy_r;
  logic               step_q;
  logic [DWELL_W-1:0] cnt;

  logic               step_rise;
  logic [2:0]         sel_nxt;
  logic               wraps;

  assign step_rise = bus.step & ~step_q;
  assign sel_nxt   = bus.dir ? (sel_r - 3'd1) : (sel_r + 3'd1);
  assign wraps     = bus.dir ? (sel_r == 3'd0) : (sel_r == 3'd7);

  assign bus.sel  = sel_r;
  assign bus.wrap = wrap_r;
  assign bus.busy = busy_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_r  <= 3'd0;
      wrap_r <= 1'b0;
      busy_r <= 1'b0;
      step_q <= 1'b0;
      cnt    <= '0;
    end else begin
      // step_q tracks in every state so a step held across RUN cannot fire on return to IDLE
      step_q <= bus.step;
      wrap_r <= 1'b0;

      if (bus.load) begin
        sel_r <= bus.load_val;
        cnt   <= '0;
      end

      unique case (state)
        IDLE: begin
          if (bus.run) begin
            state  <= RUN;
            busy_r <= 1'b1;
            cnt    <= '0;
          end else if (step_rise && !bus.load) begin
            sel_r  <= sel_nxt;
            wrap_r <= wraps;
          end
        end
        RUN: begin
          if (!bus.run) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            cnt    <= '0;
          end else if (!bus.load) begin
            // live compare: lowering dwell below the running count advances on the next edge
            if (cnt >= bus.dwell) begin
              sel_r  <= sel_nxt;
              wrap_r <= wraps;
              cnt    <= '0;
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized scoreboard bench for scan_sequencer against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_scan_sequencer;

  localparam int DWELL_W = 8;

  logic clk;
  logic rst;

  scan_sequencer_if #(.DWELL_W(DWELL_W)) sif ();

  scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       wrap;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural reference: position on the 8-entry ring, whether scanning,
  // and how many cycles the current index has been held since the last advance/transition.
  int m_sel      = 0;
  bit m_running  = 0;
  int m_held     = 0;
  bit m_prevstep = 0;
  bit m_wrap     = 0;

  task automatic drive(input bit r, input bit ru, input bit st, input bit d,
                       input bit ld, input int lv, input int dw);
    bit adv;
    bit rise;
    @(negedge clk);
    rst          = r;
    sif.run      = ru;
    sif.step     = st;
    sif.dir      = d;
    sif.load     = ld;
    sif.load_val = 3'(lv);
    sif.dwell    = DWELL_W'(dw);

    if (r) begin
      m_sel = 0; m_running = 0; m_held = 0; m_prevstep = 0; m_wrap = 0;
    end else begin
      rise       = st && !m_prevstep;
      m_prevstep = st;
      m_wrap     = 0;
      adv        = 0;
      if (m_running) begin
        if (!ru) begin
          m_running = 0; m_held = 0;
        end else if (!ld) begin
          if (m_held >= dw) begin adv = 1; m_held = 0; end
          else m_held++;
        end
      end else begin
        if (ru) begin
          m_running = 1; m_held = 0;
        end else if (rise && !ld) begin
          adv = 1;
        end
      end
      if (ld) begin
        m_sel  = lv % 8;
        m_held = 0;
      end
      if (adv) begin
        m_wrap = d ? (m_sel == 0) : (m_sel == 7);
        m_sel  = (m_sel + (d ? 7 : 1)) % 8;
      end
    end
    exp_q.push_back('{sel: 3'(m_sel), wrap: m_wrap, busy: m_running});
  endtask

  // Monitor: each edge the DUT presents a fresh registered output; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (sif.sel !== e.sel) begin
          n_fail++;
          $display("FAIL sel @%0t: got %0d expected %0d", $time, sif.sel, e.sel);
        end
        n_checks++;
        if (sif.wrap !== e.wrap) begin
          n_fail++;
          $display("FAIL wrap @%0t: got %b expected %b", $time, sif.wrap, e.wrap);
        end
        n_checks++;
        if (sif.busy !== e.busy) begin
          n_fail++;
          $display("FAIL busy @%0t: got %b expected %b", $time, sif.busy, e.busy);
        end
      end
    end
  end

  initial begin
    bit r_run;
    bit r_dir;
    int r_dwell;
    rst = 1'b1; sif.run = 0; sif.step = 0; sif.dir = 0;
    sif.load = 0; sif.load_val = '0; sif.dwell = '0;

    // reset then full up-sweep at dwell 0
    repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
    repeat (10) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // dwell hold of 4 cycles, then drop dwell to 1 while the count sits at 2
    repeat (11) drive(0, 1, 0, 0, 0, 0, 3);
    repeat (5) drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    // down count through 0 -> 7
    drive(0, 0, 0, 0, 1, 1, 0);
    repeat (5) drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);

    // single step: held step gives one advance, second pulse gives another
    drive(0, 0, 0, 0, 1, 5, 0);
    repeat (5) drive(0, 0, 1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

    // load wins over a RUN advance, scanning resumes from the loaded value
    repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 3, 0);
    repeat (4) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // run rise together with a step edge: step ignored
    drive(0, 1, 1, 0, 0, 0, 4);
    repeat (2) drive(0, 1, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 0, 4);

    // reset mid-dwell at sel=7
    drive(0, 0, 0, 0, 1, 7, 5);
    repeat (3) drive(0, 1, 0, 0, 0, 0, 5);
    drive(1, 1, 0, 0, 0, 0, 5);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0, 0, 0);

    // randomized traffic
    r_run = 0; r_dir = 0; r_dwell = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) r_run = ~r_run;
      if ($urandom_range(0, 7) == 0) r_dir = ~r_dir;
      if ($urandom_range(0, 9) == 0)
        r_dwell = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
      drive(($urandom_range(0, 99) == 0), r_run, ($urandom_range(0, 2) == 0), r_dir,
            ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)), r_dwell);
    end

    // drain scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
